// File: rtl/avr109_uart_rx_pkg.sv
// Shared definitions for the AVR109 serial link: receiver state encoding and
// the bit-timing helper the matching transmitter uses as well.
package avr109_uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Clocks per bit, rounded to nearest; tx and rx must agree on this value.
    function automatic int unsigned bit_clks(input int unsigned clk_hz,
                                             input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/avr109_sync2.sv
// Two-flop synchronizer for an asynchronous input, with a selectable reset level.
module avr109_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb sync_d = {sync_q[0], d};

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= {2{RST_VAL}};
        else     sync_q <= sync_d;
    end

    assign q = sync_q[1];

endmodule

// File: rtl/avr109_uart_rx.sv
// 8N1 serial receiver feeding the AVR109 command engine; each bit is resolved
// by a 3-sample majority vote around mid-bit.
module avr109_uart_rx #(
    parameter int unsigned CLK_FREQUENCY = 1000000,
    parameter int unsigned BAUD_RATE     = 19200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rx_enabled,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    output logic       frame_err
);
    import avr109_uart_rx_pkg::*;

    localparam int unsigned BIT_CLKS = bit_clks(CLK_FREQUENCY, BAUD_RATE);
    localparam int unsigned HALF     = BIT_CLKS / 2;
    localparam int unsigned CNT_W    = $clog2(BIT_CLKS);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_S0     = cnt_t'(HALF - 1);
    localparam cnt_t CNT_S1     = cnt_t'(HALF);
    localparam cnt_t CNT_DECIDE = cnt_t'(HALF + 1);
    localparam cnt_t CNT_LAST   = cnt_t'(BIT_CLKS - 1);

    logic      line;
    rx_state_e state_q, state_d;
    cnt_t      cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic      s0_q, s0_d, s1_q, s1_d;
    logic      armed_q, armed_d;
    logic [1:0] warm_q, warm_d;
    logic      avail_q, avail_d;
    logic      ferr_q, ferr_d;
    logic      at_wrap, at_decide, vote;

    avr109_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (line)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        armed_d   = armed_q;
        avail_d   = 1'b0;
        ferr_d    = 1'b0;
        warm_d    = {warm_q[0], 1'b1};
        at_wrap   = (cnt_q == CNT_LAST);
        at_decide = (cnt_q == CNT_DECIDE);
        vote      = majority3(s0_q, s1_q, line);

        if (state_q != ST_IDLE) cnt_d = at_wrap ? '0 : cnt_q + 1'b1;
        if (cnt_q == CNT_S0) s0_d = line;
        if (cnt_q == CNT_S1) s1_d = line;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // The synchronizer shows its reset value for two cycles; only
                // arm once it reflects the real line.
                if (warm_q[1] && line) armed_d = 1'b1;
                if (rx_enabled && armed_q && !line) begin
                    state_d = ST_START;
                    armed_d = 1'b0;
                end
            end
            ST_START: begin
                if (at_decide && vote) begin
                    state_d = ST_IDLE;
                end else if (at_wrap) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (at_decide) shift_d = {vote, shift_q[7:1]};
                if (at_wrap) begin
                    if (idx_q == 3'd7) state_d = ST_STOP;
                    else               idx_d   = idx_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (at_decide) begin
                    if (vote) begin
                        data_d  = shift_q;
                        avail_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (line) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Disabling discards any partial frame silently.
        if (!rx_enabled) begin
            state_d = ST_IDLE;
            data_d  = data_q;
            avail_d = 1'b0;
            ferr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            armed_q <= 1'b0;
            warm_q  <= '0;
            avail_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            armed_q <= armed_d;
            warm_q  <= warm_d;
            avail_q <= avail_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_avail  = avail_q;
    assign frame_err = ferr_q;

endmodule

// File: doc/avr109_uart_rx.md
Name: avr109_uart_rx

Overview:
- Serial receiver that sits directly upstream of the AVR109 bootloader command engine.
- Converts the asynchronous rxd line into bytes, with a one-cycle rx_avail strobe per byte.
- Frame format is 8N1, LSB first. Each bit is resolved by 3-sample majority vote at mid-bit.
- Reports framing errors separately and never delivers a byte with a bad stop bit.

Parameters:
CLK_FREQUENCY, 1000000, system clock frequency in Hz.
BAUD_RATE, 19200, line rate in baud.
BIT_CLKS (localparam), (CLK_FREQUENCY + BAUD_RATE/2)/BAUD_RATE, clocks per bit, rounded; default 52; must be >= 8.
HALF (localparam), BIT_CLKS/2, mid-bit sample point; default 26.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-high reset.
rxd  in  1  asynchronous serial input, idle high.
rx_enabled  in  1  receive enable; low forces IDLE and suppresses start detection.
rx_data  out  8  last good byte; held until the next good byte.
rx_avail  out  1  one-cycle pulse; rx_data is valid in the same cycle.
frame_err  out  1  one-cycle pulse when the stop bit samples low.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - rx_data=0x00, rx_avail=0, frame_err=0.
  - Both synchronizer flops = 1; state=IDLE; armed=0.
  - Bit counter, bit index and shift register = 0.
- Synchronizer: 2 flops on rxd; sync2 is the only line value used by the logic.
- armed flag:
  - Set in IDLE when sync2=1.
  - Cleared on leaving IDLE and on reset.
  - Purpose: a line held low when reset releases is never taken as a start bit.
- Bit timing:
  - cnt runs 0..BIT_CLKS-1 and wraps at BIT_CLKS-1; it is cleared to 0 on start detect.
  - Samples are taken at cnt=HALF-1 and HALF; the decision is made at cnt=HALF+1 as majority(s0, s1, sync2).
- States:
  - IDLE: if rx_enabled & armed & sync2=0 -> START, cnt=0.
  - START: at the decision point, majority=1 (false start/glitch) -> IDLE; majority=0 -> continue. On cnt wrap -> DATA with bit index=0.
  - DATA: at the decision point, shift the majority in at the MSB (shift right); 8 bits, LSB first. On cnt wrap after bit 7 -> STOP.
  - STOP: at the decision point:
    - majority=1: rx_data<=shift register, rx_avail=1 for one cycle, go to IDLE immediately (no wait for end of stop bit), so back-to-back frames are accepted.
    - majority=0: frame_err=1 for one cycle, rx_data unchanged, go to BREAK.
  - BREAK: wait for sync2=1, then -> IDLE.
- rx_enabled low:
  - In any state, the next edge goes to IDLE and the partial frame is discarded.
  - No rx_avail and no frame_err pulse.
- Latency: rx_avail is high in the cycle starting at edge E0+9*BIT_CLKS+HALF+4, exactly, where E0 is the first edge at which rxd=0 is captured. Default: 498 cycles.
- Outputs are registered; rx_avail and frame_err are never both high.
- Reset mid-frame aborts immediately; with armed=0, the remainder of the frame is ignored until the line returns high.

Decomposition:
- Shared include: state encodings IDLE/START/DATA/STOP/BREAK; a BIT_CLKS helper macro shared with the matching transmitter so both derive identical bit timing.
- One sub-module: avr109_sync2, a 2-flop synchronizer with reset value parameter RST_VAL=1.

Test Plan:
- Default parameters, frame 0x55 (start, 10101010, stop) at 52 clk/bit -> rx_data=0x55, single rx_avail pulse at cycle 498 after E0, frame_err never high.
- rxd low for 10 cycles, then high -> START rejects it at the decision point, back in IDLE, no pulses; a following 0xA5 frame is received correctly.
- Frame 0x3C with stop bit driven low, then line high after 2 bit times -> frame_err pulse, rx_avail stays 0, rx_data retains the previous value; a next frame 0x81 is received.
- Back-to-back 0xA5, 0x3C, 0xFF, each with a stop bit exactly BIT_CLKS long -> three rx_avail pulses with matching data, 520 cycles apart.
- 1-cycle inverted glitch at cnt=HALF in every data bit of 0x00 -> majority rejects the glitches, rx_data=0x00.
- Two abort cases:
  - rx_enabled dropped during bit 4 of 0x77 -> no pulse, rx_data unchanged.
  - Reset asserted mid-frame with rxd held low at release -> no start until rxd goes high; a subsequent 0x1B is received.
